stitch_pipeline_elastic: RTL and testbench
==========================================

Name: stitch_pipeline_elastic

Overview:
- Parametrised, elastic successor to the fixed two-stage stitched pipeline wrapper.
- Carries a DATA_W-bit payload through NUM_STAGES register stages, each guarded by a valid bit.
- Uses valid/ready handshakes at both ends, collapses bubbles and supports a synchronous flush.
- Sits between stitched per-cycle combinational stages and downstream consumers that can stall; the stage datapath is identity (pass-through).

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- NUM_STAGES, 2, number of register stages, which is the zero-stall latency (>=1; 0 is an elaboration error).
- OCC_W, $clog2(NUM_STAGES+1), width of the occupancy output (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  DATA_W  upstream payload.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  DATA_W  payload of the last stage.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data.
- flush  input  1  discard all in-flight data.
- occupancy  output  OCC_W  count of valid stages.

Behaviour:
- State: v[i] and d[i] for i=0..NUM_STAGES-1. Stage 0 takes input; stage NUM_STAGES-1 drives out_data/out_valid.
- Reset (rst_n==0 at posedge): all v[i]=0, all d[i]=0.
  - While rst_n is low: in_ready=0, out_valid=0, occupancy=0.
  - Reset asserted mid-stream drops all data; nothing is emitted after reset releases.
- Ready chain (combinational):
  - rdy[N-1] = !v[N-1] | out_ready
  - rdy[i] = !v[i] | rdy[i+1]
  - in_ready = rdy[0] & !flush & rst_n
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Stage update when rdy[i] (and not flush):
  - v[i] <= upstream valid (in_valid & in_ready for stage 0; v[i-1] otherwise).
  - d[i] <= upstream data only if upstream valid; otherwise d[i] holds.
- Stage with !rdy[i] holds both v and d.
- Latency: a word accepted at edge t appears on out_valid after edge t+NUM_STAGES-1 when there are no stalls (NUM_STAGES register hops). Throughput is 1 word/cycle.
- Bubble collapse: an empty stage accepts even while downstream stalls, so occupancy can reach NUM_STAGES under out_ready=0.
- Ordering: strictly FIFO. No duplication, no loss except via flush or reset.
- Full: occupancy==NUM_STAGES and out_ready=0 -> in_ready=0.
- Empty: out_valid=0; out_data holds the last value (not cleared).
- Simultaneous in and out transfer when full: permitted; occupancy unchanged.
- flush=1:
  - out_valid is forced 0 combinationally, so no output transfer occurs.
  - in_ready=0, so no input transfer occurs.
  - Next edge: all v[i]=0; d unchanged.
  - flush held for multiple cycles keeps the block empty.
  - Reset has priority over flush.
- occupancy = popcount(v), combinational from registers; 0 during flush cycle is not required (reflects registers).

Optional Feature:
- Macro: STITCH_PIPELINE_STALL_CNT_EN.
- Defined: adds output stall_count [31:0].
  - Increments each cycle out_valid & !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with in_valid=1, in_data=32'h7 -> in_ready=0, out_valid=0, occupancy=0. After release, the first accepted word is the one presented after release.
2. Streaming (DATA_W=32, NUM_STAGES=2, out_ready=1): push 7,8,9 back-to-back -> out_valid rises 2 cycles after the first accept, out_data=7,8,9 on consecutive cycles, in_ready stays 1.
3. Backpressure: out_ready=0, push 1,2,3 -> 1 and 2 accepted, in_ready=0 on the third offer, occupancy=2. Raise out_ready -> outputs 1,2,3 in order, 3 accepted the same cycle 1 leaves.
4. Bubble collapse (NUM_STAGES=4): push 0xA, idle 2 cycles, push 0xB, hold out_ready=0 -> occupancy reaches 2 with 0xA at the output. Both are delivered in order once out_ready=1.
5. Flush: with 3 words in flight (NUM_STAGES=4), assert flush for 1 cycle while in_valid=1 -> no transfers that cycle, occupancy=0 next cycle, none of the 3 words ever emitted, and the next pushed word emerges after 4 cycles.
6. STITCH_PIPELINE_STALL_CNT_EN: hold out_valid=1 with out_ready=0 for 5 cycles, then flush -> stall_count=5 and stays 5 after flush. Reset -> 0.

Source files
------------

// File: rtl/stitch_pipeline_elastic.sv
// ---------------------------------------------------------------------------
// stitch_pipeline_elastic
//
// Elastic register pipeline that carries a DATA_W-bit payload through
// NUM_STAGES valid-guarded stages. The stage datapath is identity; the block
// exists to decouple stitched per-cycle combinational logic from a consumer
// that may stall. Bubbles collapse (an empty stage always accepts), ordering
// is strictly FIFO, and a synchronous flush empties every stage at once.
//
// Parameters
//   DATA_W      payload width in bits (>= 1)
//   NUM_STAGES  number of register stages = zero-stall latency (>= 1)
//   OCC_W       derived width of the occupancy output
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   in_data      upstream payload
//   in_valid     upstream payload valid
//   in_ready     block accepts in_data this cycle
//   out_data     payload of the last stage (holds its value when empty)
//   out_valid    last stage holds valid data (forced low during flush/reset)
//   out_ready    downstream accepts out_data
//   flush        discard all in-flight data at the next edge
//   occupancy    number of valid stages
//   stall_count  (only with STITCH_PIPELINE_STALL_CNT_EN defined) saturating
//                count of cycles with out_valid high and out_ready low;
//                cleared by reset only
//
// Optional feature macro: STITCH_PIPELINE_STALL_CNT_EN
// ---------------------------------------------------------------------------
module stitch_pipeline_elastic #(
    parameter  int DATA_W     = 32,
    parameter  int NUM_STAGES = 2,
    localparam int OCC_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy
`ifdef STITCH_PIPELINE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("stitch_pipeline_elastic: NUM_STAGES must be at least 1");
    end

    logic [NUM_STAGES-1:0] stage_vld;
    logic [DATA_W-1:0]     stage_data [NUM_STAGES];
    logic [NUM_STAGES-1:0] stage_rdy;
    logic                  in_xfer;

    // A stage can take new data when it is empty or when everything in front
    // of it can move. Built back-to-front with a running term so the chain is
    // a single pass rather than a vector that reads itself.
    always_comb begin
        logic run;
        run       = out_ready;
        stage_rdy = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            run          = run | ~stage_vld[i];
            stage_rdy[i] = run;
        end
    end

    assign in_ready  = stage_rdy[0] & ~flush & rst_n;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = stage_vld[NUM_STAGES-1] & ~flush & rst_n;
    assign out_data  = stage_data[NUM_STAGES-1];

    // Occupancy reflects the registers directly; only reset masks it.
    always_comb begin
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cnt = cnt + OCC_W'(stage_vld[i]);
        end
        occupancy = rst_n ? cnt : '0;
    end

    // Stage registers: a ready stage loads its upstream neighbour's valid bit
    // and copies data only when that neighbour is valid, so an empty stage
    // leaves its payload untouched. Flush clears valids and keeps data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_vld <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else if (flush) begin
            stage_vld <= '0;
        end else begin
            if (stage_rdy[0]) begin
                stage_vld[0] <= in_xfer;
                if (in_xfer) begin
                    stage_data[0] <= in_data;
                end
            end
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (stage_rdy[i]) begin
                    stage_vld[i] <= stage_vld[i-1];
                    if (stage_vld[i-1]) begin
                        stage_data[i] <= stage_data[i-1];
                    end
                end
            end
        end
    end

`ifdef STITCH_PIPELINE_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Counts cycles where valid output is being held back by the consumer.
    // out_valid is already masked by flush, so flush cycles never count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready) begin
            stall_count <= sat_inc(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_stitch_pipeline_elastic.sv
// ---------------------------------------------------------------------------
// Testbench for stitch_pipeline_elastic. Two instances (2 and 4 stages) share
// one stimulus stream. A reference model keeps each instance's contents as a
// FIFO of (word, age-in-edges) entries: input is ready when the FIFO is not
// full or the consumer is ready, and the oldest word is visible once it has
// aged NUM_STAGES-1 edges.
// ---------------------------------------------------------------------------
module tb_stitch_pipeline_elastic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        flush;

    logic        irdy2, irdy4, ovld2, ovld4;
    logic [31:0] odat2, odat4;
    logic [1:0]  occ2;
    logic [2:0]  occ4;
    logic [31:0] scnt2, scnt4;

    logic        irdy [2];
    logic        ovld [2];
    logic [31:0] odat [2];
    logic [31:0] scnt [2];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] md  [2][8];
    int          ma  [2][8];
    int          mn  [2] = '{0, 0};
    logic [31:0] mst [2] = '{32'd0, 32'd0};

    always #5 clk = ~clk;

    stitch_pipeline_elastic #(.DATA_W(32), .NUM_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(irdy2), .out_data(odat2), .out_valid(ovld2),
        .out_ready(out_ready), .flush(flush), .occupancy(occ2)
`ifdef STITCH_PIPELINE_STALL_CNT_EN
        , .stall_count(scnt2)
`endif
    );

    stitch_pipeline_elastic #(.DATA_W(32), .NUM_STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(irdy4), .out_data(odat4), .out_valid(ovld4),
        .out_ready(out_ready), .flush(flush), .occupancy(occ4)
`ifdef STITCH_PIPELINE_STALL_CNT_EN
        , .stall_count(scnt4)
`endif
    );

`ifndef STITCH_PIPELINE_STALL_CNT_EN
    assign scnt2 = 32'd0;
    assign scnt4 = 32'd0;
`endif

    assign irdy[0] = irdy2;
    assign irdy[1] = irdy4;
    assign ovld[0] = ovld2;
    assign ovld[1] = ovld4;
    assign odat[0] = odat2;
    assign odat[1] = odat4;
    assign scnt[0] = scnt2;
    assign scnt[1] = scnt4;

    // Scoreboard: compare both instances against the model, then advance the
    // model with the inputs that the coming edge will sample.
    always @(negedge clk) begin
        bit eir, eov;
        int eocc, aocc, ns;
        for (int k = 0; k < 2; k++) begin
            ns   = (k == 0) ? 2 : 4;
            aocc = (k == 0) ? int'(occ2) : int'(occ4);
            eir  = rst_n && !flush && (mn[k] < ns || out_ready);
            eov  = rst_n && !flush && mn[k] > 0 && ma[k][0] >= ns - 1;
            eocc = rst_n ? mn[k] : 0;
            checks++;
            if (irdy[k] !== eir) begin
                errors++;
                $display("FAIL mon_in_ready n=%0d got %b exp %b t=%0t", ns, irdy[k], eir, $time);
            end
            checks++;
            if (ovld[k] !== eov) begin
                errors++;
                $display("FAIL mon_out_valid n=%0d got %b exp %b t=%0t", ns, ovld[k], eov, $time);
            end
            checks++;
            if (aocc != eocc) begin
                errors++;
                $display("FAIL mon_occupancy n=%0d got %0d exp %0d t=%0t", ns, aocc, eocc, $time);
            end
            if (eov) begin
                checks++;
                if (odat[k] !== md[k][0]) begin
                    errors++;
                    $display("FAIL mon_out_data n=%0d got %h exp %h t=%0t", ns, odat[k], md[k][0], $time);
                end
            end
`ifdef STITCH_PIPELINE_STALL_CNT_EN
            checks++;
            if (scnt[k] !== mst[k]) begin
                errors++;
                $display("FAIL mon_stall_count n=%0d got %0d exp %0d t=%0t", ns, scnt[k], mst[k], $time);
            end
`endif
            if (!rst_n) begin
                mn[k]  = 0;
                mst[k] = 32'd0;
            end else if (flush) begin
                mn[k] = 0;
            end else begin
                if (eov && !out_ready && mst[k] != 32'hFFFF_FFFF) mst[k] = mst[k] + 32'd1;
                if (eov && out_ready) begin
                    for (int j = 0; j < 7; j++) begin
                        md[k][j] = md[k][j+1];
                        ma[k][j] = ma[k][j+1];
                    end
                    mn[k]--;
                end
                for (int j = 0; j < mn[k]; j++) ma[k][j]++;
                if (in_valid && eir) begin
                    md[k][mn[k]] = in_data;
                    ma[k][mn[k]] = 0;
                    mn[k]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        int nout;
        logic [31:0] first;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (irdy2 !== 1'b0 || irdy4 !== 1'b0) begin
                errors++; $display("FAIL reset_in_ready got %b%b exp 00", irdy2, irdy4);
            end
            checks++;
            if (ovld2 !== 1'b0 || ovld4 !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid got %b%b exp 00", ovld2, ovld4);
            end
            checks++;
            if (occ2 !== 2'd0 || occ4 !== 3'd0) begin
                errors++; $display("FAIL reset_occupancy got %0d/%0d exp 0/0", occ2, occ4);
            end
            tick();
        end
        rst_n = 1'b1; in_data = 32'h55;
        nout = 0; first = 32'h0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) in_valid = 1'b0;
            @(negedge clk);
            if (ovld2) begin
                if (nout == 0) first = odat2;
                nout++;
            end
            tick();
        end
        checks++;
        if (nout != 1 || first !== 32'h55) begin
            errors++; $display("FAIL reset_first_word got %0d words first %h exp 1 words first 00000055", nout, first);
        end
    endtask

    task automatic test_reset_midstream();
        int bad;
        drain();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 32'hA0 + c;
            tick();
        end
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ovld2 || ovld4) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midstream_reset_emit got %0d valid cycles exp 0", bad);
        end
    endtask

    task automatic test_stream();
        int cyc [2][3];
        logic [31:0] val [2][3];
        int n [2];
        drain();
        n = '{0, 0};
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 3);
            in_data  = 32'd7 + c;
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if (irdy2 !== 1'b1 || irdy4 !== 1'b1) begin
                    errors++; $display("FAIL stream_in_ready c=%0d got %b%b exp 11", c, irdy2, irdy4);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (ovld[k] && n[k] < 3) begin
                    cyc[k][n[k]] = c;
                    val[k][n[k]] = odat[k];
                    n[k]++;
                end
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (n[k] != 3) begin
                errors++; $display("FAIL stream_count n=%0d got %0d exp 3", k ? 4 : 2, n[k]);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (val[k][i] !== 32'd7 + i || cyc[k][i] != (k ? 4 : 2) + i) begin
                        errors++;
                        $display("FAIL stream_word n=%0d i=%0d got %h@%0d exp %h@%0d", k ? 4 : 2, i,
                                 val[k][i], cyc[k][i], 32'd7 + i, (k ? 4 : 2) + i);
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if (ovld2 !== 1'b0 || odat2 !== 32'd9 || odat4 !== 32'd9) begin
            errors++; $display("FAIL empty_holds_data got %b %h %h exp 0 00000009 00000009", ovld2, odat2, odat4);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] got [$];
        drain();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 32'd1 + c;
            @(negedge clk);
            checks++;
            if (irdy2 !== (c < 2)) begin
                errors++; $display("FAIL bp_in_ready c=%0d got %b exp %b", c, irdy2, c < 2);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (occ2 !== 2'd2) begin
            errors++; $display("FAIL bp_occupancy got %0d exp 2", occ2);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (irdy2 !== 1'b1 || ovld2 !== 1'b1 || odat2 !== 32'd1) begin
            errors++; $display("FAIL bp_swap got rdy %b vld %b data %h exp 1 1 00000001", irdy2, ovld2, odat2);
        end
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ovld2) got.push_back(odat2);
            tick();
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'd2 || got[1] !== 32'd3) begin
            errors++; $display("FAIL bp_order got %0d words exp 2,3", got.size());
        end
    endtask

    task automatic test_bubble();
        logic [31:0] got [$];
        drain();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0 || c == 3);
            in_data  = (c == 0) ? 32'hA : 32'hB;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (occ4 !== 3'd2 || ovld4 !== 1'b1 || odat4 !== 32'hA) begin
            errors++; $display("FAIL bubble_state got occ %0d vld %b data %h exp 2 1 0000000a", occ4, ovld4, odat4);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ovld4) got.push_back(odat4);
            tick();
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'hA || got[1] !== 32'hB) begin
            errors++; $display("FAIL bubble_order got %0d words exp a,b", got.size());
        end
    endtask

    task automatic test_flush();
        int nv, at;
        logic [31:0] w;
        drain();
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 32'h11 * (c + 1);
            tick();
        end
        flush = 1'b1; in_data = 32'h44;
        @(negedge clk);
        checks++;
        if (irdy2 !== 1'b0 || irdy4 !== 1'b0 || ovld2 !== 1'b0 || ovld4 !== 1'b0) begin
            errors++; $display("FAIL flush_no_xfer got rdy %b%b vld %b%b exp 00 00", irdy2, irdy4, ovld2, ovld4);
        end
        tick();
        flush = 1'b0; in_data = 32'hF00D;
        @(negedge clk);
        checks++;
        if (occ4 !== 3'd0 || occ2 !== 2'd0) begin
            errors++; $display("FAIL flush_empty got %0d/%0d exp 0/0", occ2, occ4);
        end
        tick();
        in_valid = 1'b0;
        nv = 0; at = 0; w = 32'h0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (ovld4) begin
                nv++; at = j; w = odat4;
            end
            tick();
        end
        checks++;
        if (nv != 1 || at != 4 || w !== 32'hF00D) begin
            errors++; $display("FAIL flush_next_word got %0d words at %0d data %h exp 1 at 4 0000f00d", nv, at, w);
        end
    endtask

    task automatic test_multi_flush();
        drain();
        in_valid = 1'b1; in_data = 32'h99; flush = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (occ2 !== 2'd0 || occ4 !== 3'd0) begin
            errors++; $display("FAIL multi_flush_empty got %0d/%0d exp 0/0", occ2, occ4);
        end
        tick();
        flush = 1'b0;
    endtask

`ifdef STITCH_PIPELINE_STALL_CNT_EN
    task automatic test_stall_count();
        bit seen;
        drain();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (scnt4 !== 32'd0) begin
            errors++; $display("FAIL stall_reset got %0d exp 0", scnt4);
        end
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5A;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ovld4) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL stall_wait_valid got timeout exp out_valid");
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (scnt4 !== 32'd5) begin
                errors++; $display("FAIL stall_count c=%0d got %0d exp 5", c, scnt4);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (scnt4 !== 32'd0 || scnt2 !== 32'd0) begin
            errors++; $display("FAIL stall_clear got %0d/%0d exp 0/0", scnt2, scnt4);
        end
        tick();
        rst_n = 1'b1;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 3);
            rst_n     = !($urandom_range(0, 199) == 0);
            tick();
        end
        rst_n = 1'b1;
        drain();
        @(negedge clk);
        checks++;
        if (occ2 !== 2'd0 || occ4 !== 3'd0 || ovld2 !== 1'b0 || ovld4 !== 1'b0) begin
            errors++; $display("FAIL random_drained got occ %0d/%0d vld %b%b exp 0/0 00", occ2, occ4, ovld2, ovld4);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1; flush = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_multi_flush();
        test_reset_midstream();
`ifdef STITCH_PIPELINE_STALL_CNT_EN
        test_stall_count();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
